disp_sched: RTL

- Display page scheduler for the temperature monitor board.
- Decides which page the 4-digit seven-seg bank shows: temperature, monitor state, or blank.
- Page time is counted in 1 Hz tick strobes.
- A monitor state change preempts to the state page; emergency locks the state page. Top-level seg muxes are driven by `page`.

---
 rtl/disp_sched_if.sv | 35 +++
 rtl/disp_sched.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/disp_sched_if.sv
// Display scheduler bus: strobes and monitor inputs toward the scheduler,
// page selection and status back toward the seven-seg muxes.
// The ack signal exists only when DISP_SCHED_ACK_EN is defined.
interface disp_sched_if #(
  parameter int CNT_W = 4
);
  logic             tick;
  logic             hold;
  logic [3:0]       state_code;
  logic [1:0]       alarm_level;
`ifdef DISP_SCHED_ACK_EN
  logic             ack;
`endif
  logic [1:0]       page;
  logic             blank;
  logic             locked;
  logic             changed;
  logic [CNT_W-1:0] dwell_cnt;

  modport master (
`ifdef DISP_SCHED_ACK_EN
    output ack,
`endif
    output tick, hold, state_code, alarm_level,
    input  page, blank, locked, changed, dwell_cnt
  );

  modport slave (
`ifdef DISP_SCHED_ACK_EN
    input  ack,
`endif
    input  tick, hold, state_code, alarm_level,
    output page, blank, locked, changed, dwell_cnt
  );
endinterface

// File: rtl/disp_sched.sv
// Display page scheduler: cycles temp / blank / state / blank pages on 1 Hz
// ticks, preempts to the state page on a monitor state change and locks the
// state page during an emergency.
// Optional macro DISP_SCHED_ACK_EN: adds an ack input that releases the lock
// until the alarm has cleared and re-asserted.
module disp_sched #(
  parameter int TEMP_DWELL  = 3,
  parameter int STATE_DWELL = 2,
  parameter int BLANK_TICKS = 1,
  parameter int CNT_W       = 4
) (
  input  logic          clk,
  input  logic          rst,
  disp_sched_if.slave   bus
);

  typedef enum logic [2:0] {
    SHOW_TEMP  = 3'd0,
    BLANK_TS   = 3'd1,
    SHOW_STATE = 3'd2,
    BLANK_ST   = 3'd3,
    LOCK       = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] TEMP_LIM  = CNT_W'(TEMP_DWELL);
  localparam logic [CNT_W-1:0] STATE_LIM = CNT_W'(STATE_DWELL);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_TICKS);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] dwell_reg, dwell_next, limit;
  logic [3:0]       prev_state_reg;
  logic [1:0]       page_reg, page_next;
  logic             blank_reg, locked_reg, changed_reg;
  logic             change, emerg, advance, lock_enter, lock_exit;

  assign change  = (bus.state_code != prev_state_reg);
  assign emerg   = (bus.alarm_level >= 2'd2);
  assign advance = bus.tick && !bus.hold;

`ifdef DISP_SCHED_ACK_EN
  logic acked_reg, acked_next;

  // An ack releases the lock; the flag blocks re-entry until the alarm clears.
  always_comb begin
    acked_next = acked_reg;
    if (!emerg)
      acked_next = 1'b0;
    else if (state_reg == LOCK && bus.ack)
      acked_next = 1'b1;
  end

  assign lock_enter = (state_reg != LOCK) && emerg && !acked_reg;
  assign lock_exit  = (state_reg == LOCK) && (!emerg || bus.ack);
`else
  assign lock_enter = (state_reg != LOCK) && emerg;
  assign lock_exit  = (state_reg == LOCK) && !emerg;
`endif

  // Dwell limit for the current page; attention shortens the temperature page.
  always_comb begin
    limit = TEMP_LIM;
    unique case (state_reg)
      SHOW_TEMP:          limit = (bus.alarm_level == 2'd1) ? ONE : TEMP_LIM;
      SHOW_STATE:         limit = STATE_LIM;
      BLANK_TS, BLANK_ST: limit = BLANK_LIM;
      default:            limit = TEMP_LIM;
    endcase
  end

  // Next state and dwell count: lock entry/exit > change preempt > advance.
  always_comb begin
    state_next = state_reg;
    dwell_next = dwell_reg;
    if (lock_enter) begin
      state_next = LOCK;
      dwell_next = '0;
    end else if (lock_exit) begin
      state_next = SHOW_STATE;
      dwell_next = '0;
    end else if (state_reg == LOCK) begin
      dwell_next = '0;
    end else if (change) begin
      state_next = SHOW_STATE;
      dwell_next = '0;
    end else if (advance) begin
      if (dwell_reg == limit - ONE) begin
        dwell_next = '0;
        unique case (state_reg)
          SHOW_TEMP:  state_next = (BLANK_TICKS == 0) ? SHOW_STATE : BLANK_TS;
          BLANK_TS:   state_next = SHOW_STATE;
          SHOW_STATE: state_next = (BLANK_TICKS == 0) ? SHOW_TEMP : BLANK_ST;
          BLANK_ST:   state_next = SHOW_TEMP;
          default:    state_next = SHOW_TEMP;
        endcase
      end else begin
        dwell_next = dwell_reg + ONE;
      end
    end
  end

  // Page shown for the upcoming state; registered alongside the state.
  always_comb begin
    page_next = 2'd0;
    unique case (state_next)
      SHOW_TEMP:          page_next = 2'd0;
      SHOW_STATE, LOCK:   page_next = 2'd1;
      BLANK_TS, BLANK_ST: page_next = 2'd2;
      default:            page_next = 2'd0;
    endcase
  end

  // State, counter and registered outputs; prev_state tracks the input
  // even in reset so release never produces a spurious change pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= SHOW_TEMP;
      dwell_reg      <= '0;
      prev_state_reg <= bus.state_code;
      page_reg       <= 2'd0;
      blank_reg      <= 1'b0;
      locked_reg     <= 1'b0;
      changed_reg    <= 1'b0;
`ifdef DISP_SCHED_ACK_EN
      acked_reg      <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      dwell_reg      <= dwell_next;
      prev_state_reg <= bus.state_code;
      page_reg       <= page_next;
      blank_reg      <= (page_next == 2'd2);
      locked_reg     <= (state_next == LOCK);
      changed_reg    <= change;
`ifdef DISP_SCHED_ACK_EN
      acked_reg      <= acked_next;
`endif
    end
  end

  assign bus.page      = page_reg;
  assign bus.blank     = blank_reg;
  assign bus.locked    = locked_reg;
  assign bus.changed   = changed_reg;
  assign bus.dwell_cnt = dwell_reg;

endmodule
